router_pkt_gen: RTL and testbench
=================================

Name: router_pkt_gen

Overview:
- Packet source for the router input port: drives pkt_valid/data_in in the router's packet format (header, payload, parity) and honours the router's busy back-pressure.
- Used as an on-chip traffic generator/BIST for the Tiny Tapeout router.
- Payload comes from an internal 8-bit LFSR, so every packet is deterministic and checkable.
- Error-injection mode emits a corrupted parity byte to exercise the router's err path.

Parameters:
- DATA_W, 8, byte width of data_out, header, payload and parity; fixed 8 for the router format.
- LEN_W, 6, payload-length field width (header bits [7:2]).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request one packet; sampled only in IDLE.
- dest_addr  input  2  destination port, header bits [1:0].
- payload_len  input  6  payload byte count, 1..63.
- seed  input  8  LFSR seed for this packet.
- bad_parity  input  1  when 1 at start, parity byte is sent inverted.
- busy  input  1  router back-pressure; the presented byte is held while 1.
- pkt_valid  output  1  high during header and payload, low during the parity byte (router protocol).
- data_out  output  8  byte to router data_in.
- tx_active  output  1  high from header through parity.
- done  output  1  one-cycle pulse after the parity byte is consumed.
- pkt_count  output  8  count of completed packets, wraps 255 -> 0.

Behaviour:
- Reset (async, any time, including mid-packet):
  - state=IDLE; pkt_valid=0, data_out=0, tx_active=0, done=0, pkt_count=0.
  - LFSR, parity accumulator and length counter cleared.
- All outputs are registered. A byte on data_out is consumed by the router on a rising edge where busy==0. With busy==1, all outputs, LFSR, counter and state hold.
- States:
  - IDLE: on an edge with start=1 and payload_len!=0, latch len/addr/bad_parity, LFSR<=seed (8'h00 replaced by 8'h01). Same edge: data_out<={payload_len,dest_addr}, pkt_valid=1, tx_active=1, parity_acc<=header; go HDR.
  - Start with payload_len==0 is ignored; no output change.
  - HDR: on consume, data_out<=LFSR, parity_acc^=LFSR, LFSR advances, remaining<=len-1; go PLD.
  - PLD: on consume, if remaining!=0, emit the next LFSR byte as in HDR and decrement remaining. If remaining==0, data_out<=parity_acc (inverted if bad_parity latched), pkt_valid<=0; go PAR.
  - PAR: on consume, data_out<=0, tx_active<=0, done<=1 for one cycle, pkt_count+=1; go IDLE.
- start is ignored in HDR/PLD/PAR and in the cycle done is high, giving a minimum 1-cycle gap between packets.
- LFSR step: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Payload byte k (k=0..) is the LFSR value after k steps, so the first payload byte equals the seed.
- Latency with busy tied 0: header visible the cycle after the start edge; the packet occupies len+2 cycles; done is high the cycle after the parity cycle.
- dest_addr=2'b11 is sent unchanged; the router drops it.
- Inputs other than busy are don't-care while tx_active=1.

Test Plan:
- Reset, then start with seed=8'h01, len=5, addr=2, bad_parity=0, busy=0.
  -> data_out sequence 16,01,02,04,08,11,08 (hex).
  -> pkt_valid=1 for 6 cycles, then 0 on parity 08.
  -> done pulse one cycle later; pkt_count=1.
- Same packet with bad_parity=1.
  -> identical bytes except parity=F7.
  -> router err asserts when the router is the load.
- Same packet, busy=1 for 3 cycles while byte 04 is presented.
  -> data_out=04, pkt_valid=1 and state held 3 cycles.
  -> total length 10 cycles; parity still 08.
- start with payload_len=0 -> no activity, tx_active stays 0. start pulsed mid-packet -> ignored, packet unchanged. seed=8'h00 -> first payload byte 01.
- Assert reset during PLD (after byte 02).
  -> all outputs 0 immediately (async), pkt_count=0.
  -> next start yields a complete fresh packet.
- 256 back-to-back len=1 packets -> pkt_count wraps to 0; done pulses exactly 256 times.

Source files
------------

// File: rtl/router_pkt_gen_if.sv
// Request and router-side signals of the router packet generator.
// The generator takes the master view; the router/test harness takes the slave view.
interface router_pkt_gen_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
);
  logic              start;
  logic [1:0]        dest_addr;
  logic [LEN_W-1:0]  payload_len;
  logic [DATA_W-1:0] seed;
  logic              bad_parity;
  logic              busy;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_out;
  logic              tx_active;
  logic              done;
  logic [7:0]        pkt_count;

  modport master (
    input  start, dest_addr, payload_len, seed, bad_parity, busy,
    output pkt_valid, data_out, tx_active, done, pkt_count
  );

  modport slave (
    output start, dest_addr, payload_len, seed, bad_parity, busy,
    input  pkt_valid, data_out, tx_active, done, pkt_count
  );
endinterface

// File: rtl/router_pkt_gen.sv
// Deterministic packet source for the router input port: header, LFSR payload,
// parity byte, with busy back-pressure and optional parity corruption.
module router_pkt_gen #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic                clock,
  input  logic                reset,
  router_pkt_gen_if.master    pkt
);

  typedef enum logic [1:0] {IDLE, HDR, PLD, PAR} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              bad_q, bad_d;
  logic              valid_q, valid_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic [7:0]        count_q, count_d;

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] seed_nz;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign header  = {pkt.payload_len, pkt.dest_addr};
  // An all-zero seed would lock the LFSR at zero.
  assign seed_nz = (pkt.seed == '0) ? DATA_W'(1) : pkt.seed;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case leaves it unassigned (no latches).
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    parity_d = parity_q;
    data_d   = data_q;
    len_d    = len_q;
    rem_d    = rem_q;
    bad_d    = bad_q;
    valid_d  = valid_q;
    active_d = active_q;
    done_d   = 1'b0;
    count_d  = count_q;

    unique case (state_q)
      IDLE: begin
        // The done cycle blocks a new start, forcing a gap between packets.
        if (pkt.start && !done_q && pkt.payload_len != '0) begin
          len_d    = pkt.payload_len;
          bad_d    = pkt.bad_parity;
          lfsr_d   = seed_nz;
          data_d   = header;
          parity_d = header;
          valid_d  = 1'b1;
          active_d = 1'b1;
          state_d  = HDR;
        end
      end

      HDR: begin
        if (!pkt.busy) begin
          data_d   = lfsr_q;
          parity_d = parity_q ^ lfsr_q;
          lfsr_d   = lfsr_step(lfsr_q);
          rem_d    = len_q - LEN_W'(1);
          state_d  = PLD;
        end
      end

      PLD: begin
        if (!pkt.busy) begin
          if (rem_q != '0) begin
            data_d   = lfsr_q;
            parity_d = parity_q ^ lfsr_q;
            lfsr_d   = lfsr_step(lfsr_q);
            rem_d    = rem_q - LEN_W'(1);
          end else begin
            data_d  = bad_q ? ~parity_q : parity_q;
            valid_d = 1'b0;
            state_d = PAR;
          end
        end
      end

      PAR: begin
        if (!pkt.busy) begin
          data_d   = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          count_d  = count_q + 8'd1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= '0;
      parity_q <= '0;
      data_q   <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      bad_q    <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      bad_q    <= bad_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign pkt.pkt_valid = valid_q;
  assign pkt.data_out  = data_q;
  assign pkt.tx_active = active_q;
  assign pkt.done      = done_q;
  assign pkt.pkt_count = count_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Scoreboard bench for router_pkt_gen: expected bytes are queued when a packet
// is requested and compared, byte by byte, as the generator presents them.
module tb_router_pkt_gen;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  router_pkt_gen_if bus ();

  router_pkt_gen dut (
    .clock (clock),
    .reset (reset),
    .pkt   (bus)
  );

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  int         done_seen = 0;
  logic [7:0] exp_count = 8'd0;
  logic [8:0] exp_q[$];

  always @(negedge clock) if (bus.done === 1'b1) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic fb;
    fb = ^(v & 8'b1011_1000);
    return {v[6:0], fb};
  endfunction

  // Sends one packet and compares every presented byte with the queued model.
  task automatic run_pkt(input logic [1:0] addr, input logic [5:0] len, input logic [7:0] seed,
                         input logic bad, input int busy_at, input int busy_n,
                         input logic mid_start, output int cycles);
    logic [7:0] l, par, hdr;
    int idx, held;
    hdr = {len, addr};
    par = hdr;
    l   = (seed == 8'h00) ? 8'h01 : seed;
    exp_q.push_back({1'b1, hdr});
    for (int k = 0; k < int'(len); k++) begin
      exp_q.push_back({1'b1, l});
      par = par ^ l;
      l   = lfsr_next(l);
    end
    exp_q.push_back({1'b0, bad ? ~par : par});

    @(negedge clock);
    bus.dest_addr   = addr;
    bus.payload_len = len;
    bus.seed        = seed;
    bus.bad_parity  = bad;
    bus.busy        = 1'b0;
    bus.start       = 1'b1;
    @(negedge clock);
    bus.start       = 1'b0;
    bus.dest_addr   = ~addr;
    bus.payload_len = len + 6'd3;
    bus.seed        = seed ^ 8'h5A;
    bus.bad_parity  = ~bad;

    idx = 0; held = 0; cycles = 0;
    while (exp_q.size() != 0 && cycles < 200) begin
      total_cnt++;
      if (bus.tx_active !== 1'b1 || {bus.pkt_valid, bus.data_out} !== exp_q[0])
        $display("FAIL pkt_byte[%0d]: got active=%b valid=%b data=%h, want active=1 valid=%b data=%h",
                 idx, bus.tx_active, bus.pkt_valid, bus.data_out, exp_q[0][8], exp_q[0][7:0]);
      else pass_cnt++;
      bus.start = (mid_start && idx == 2);
      if (idx == busy_at && held < busy_n) begin
        bus.busy = 1'b1;
        held++;
      end else begin
        bus.busy = 1'b0;
        void'(exp_q.pop_front());
        idx++;
      end
      @(negedge clock);
      cycles++;
    end
    bus.start = 1'b0;
    bus.busy  = 1'b0;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL pkt_timeout: %0d bytes never presented, want 0", exp_q.size());
      exp_q.delete();
    end

    exp_count++;
    total_cnt++;
    if (bus.done !== 1'b1 || bus.tx_active !== 1'b0 || bus.pkt_valid !== 1'b0 || bus.data_out !== 8'h00)
      $display("FAIL done_cycle: got done=%b active=%b valid=%b data=%h, want done=1 active=0 valid=0 data=00",
               bus.done, bus.tx_active, bus.pkt_valid, bus.data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.pkt_count !== exp_count)
      $display("FAIL pkt_count: got %0d, want %0d", bus.pkt_count, exp_count);
    else pass_cnt++;

    // A start held during the done cycle must not launch a packet on that edge.
    bus.start = mid_start;
    @(negedge clock);
    bus.start = 1'b0;
    total_cnt++;
    if (bus.done !== 1'b0 || bus.tx_active !== 1'b0)
      $display("FAIL after_done: got done=%b active=%b, want done=0 active=0", bus.done, bus.tx_active);
    else pass_cnt++;
  endtask

  task automatic check_cycles(input string name, input int got, input int want);
    total_cnt++;
    if (got !== want) $display("FAIL %s_length: got %0d cycles, want %0d", name, got, want);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.dest_addr = 2'd0; bus.payload_len = 6'd0;
    bus.seed = 8'h00; bus.bad_parity = 1'b0; bus.busy = 1'b0;
    repeat (2) @(negedge clock);
    total_cnt++;
    if ({bus.pkt_valid, bus.data_out, bus.tx_active, bus.done, bus.pkt_count} !== 19'd0)
      $display("FAIL reset_state: got valid=%b data=%h active=%b done=%b count=%0d, want all 0",
               bus.pkt_valid, bus.data_out, bus.tx_active, bus.done, bus.pkt_count);
    else pass_cnt++;
    reset = 1'b0;
    exp_count = 8'd0;
  endtask

  task automatic test_basic();
    int c;
    run_pkt(2'd2, 6'd5, 8'h01, 1'b0, -1, 0, 1'b0, c);
    check_cycles("basic", c, 7);
  endtask

  task automatic test_bad_parity();
    int c;
    run_pkt(2'd2, 6'd5, 8'h01, 1'b1, -1, 0, 1'b0, c);
    check_cycles("bad_parity", c, 7);
  endtask

  task automatic test_busy();
    int c;
    run_pkt(2'd2, 6'd5, 8'h01, 1'b0, 3, 3, 1'b0, c);
    check_cycles("busy", c, 10);
  endtask

  task automatic test_zero_len();
    @(negedge clock);
    bus.payload_len = 6'd0;
    bus.seed        = 8'h33;
    bus.start       = 1'b1;
    repeat (3) begin
      @(negedge clock);
      total_cnt++;
      if (bus.tx_active !== 1'b0 || bus.pkt_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.pkt_count !== exp_count)
        $display("FAIL zero_len: got active=%b valid=%b data=%h count=%0d, want 0/0/00/%0d",
                 bus.tx_active, bus.pkt_valid, bus.data_out, bus.pkt_count, exp_count);
      else pass_cnt++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_mid_start();
    int c;
    run_pkt(2'd3, 6'd4, 8'hA5, 1'b0, -1, 0, 1'b1, c);
    check_cycles("mid_start", c, 6);
  endtask

  task automatic test_seed_zero();
    int c;
    run_pkt(2'd1, 6'd3, 8'h00, 1'b0, 1, 2, 1'b0, c);
    check_cycles("seed_zero", c, 7);
  endtask

  task automatic test_reset_mid_packet();
    int c;
    @(negedge clock);
    bus.dest_addr = 2'd2; bus.payload_len = 6'd5; bus.seed = 8'h01;
    bus.bad_parity = 1'b0; bus.busy = 1'b0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    total_cnt++;
    if (bus.data_out !== 8'h02 || bus.pkt_valid !== 1'b1)
      $display("FAIL pre_reset_byte: got valid=%b data=%h, want valid=1 data=02", bus.pkt_valid, bus.data_out);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({bus.pkt_valid, bus.data_out, bus.tx_active, bus.done, bus.pkt_count} !== 19'd0)
      $display("FAIL async_reset: got valid=%b data=%h active=%b done=%b count=%0d, want all 0",
               bus.pkt_valid, bus.data_out, bus.tx_active, bus.done, bus.pkt_count);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    exp_count = 8'd0;
    run_pkt(2'd2, 6'd5, 8'h01, 1'b0, -1, 0, 1'b0, c);
    check_cycles("post_reset", c, 7);
  endtask

  task automatic test_back_to_back();
    int c, d0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_count = 8'd0;
    d0 = done_seen;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] s;
      s = 8'(i);
      run_pkt(s[1:0], 6'd1, s, s[2], -1, 0, 1'b0, c);
    end
    #1;
    total_cnt++;
    if (done_seen - d0 !== 256) $display("FAIL done_pulses: got %0d, want 256", done_seen - d0);
    else pass_cnt++;
    total_cnt++;
    if (bus.pkt_count !== 8'd0) $display("FAIL count_wrap: got %0d, want 0", bus.pkt_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_parity();
    test_busy();
    test_zero_len();
    test_mid_start();
    test_seed_zero();
    test_reset_mid_packet();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
